// File: rtl/sap1_pkg.sv
// sap1_pkg: shared control-word layout and opcode constants for the SAP-1 datapath and controller
package sap1_pkg;
  localparam int CP_BIT   = 11;
  localparam int EP_BIT   = 10;
  localparam int LM_N_BIT = 9;
  localparam int CE_N_BIT = 8;
  localparam int LI_N_BIT = 7;
  localparam int EI_N_BIT = 6;
  localparam int LA_N_BIT = 5;
  localparam int EA_BIT   = 4;
  localparam int SU_BIT   = 3;
  localparam int EU_BIT   = 2;
  localparam int LB_N_BIT = 1;
  localparam int LO_N_BIT = 0;
  typedef logic [11:0] cntrl_word_t;
  // Word with every strobe inactive (active-low bits high, active-high bits low)
  localparam cntrl_word_t CW_IDLE = 12'h3E3;
  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;
endpackage

// File: rtl/sap1_ram16x8.sv
// sap1_ram16x8: program/data RAM, asynchronous read, synchronous write, no reset
module sap1_ram16x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // Contents survive CLR so a loaded program can be rerun
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sap1_datapath.sv
// sap1_datapath: SAP-1 registers, W bus mux, add/sub ALU and program-load port
module sap1_datapath
  import sap1_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [11:0]       cntrl_bus,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] out_reg,
  output logic [DATA_W-1:0] w_bus,
  output logic              bus_conflict
);
  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] ir, a, b, alu, ram_q;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, conflict;
  assign cp = cntrl_bus[CP_BIT];
  assign ep = cntrl_bus[EP_BIT];
  assign lm = !cntrl_bus[LM_N_BIT];
  assign ce = !cntrl_bus[CE_N_BIT];
  assign li = !cntrl_bus[LI_N_BIT];
  assign ei = !cntrl_bus[EI_N_BIT];
  assign la = !cntrl_bus[LA_N_BIT];
  assign ea = cntrl_bus[EA_BIT];
  assign su = cntrl_bus[SU_BIT];
  assign eu = cntrl_bus[EU_BIT];
  assign lb = !cntrl_bus[LB_N_BIT];
  assign lo = !cntrl_bus[LO_N_BIT];
  sap1_ram16x8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .we    (prog_mode && prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (mar),
    .rdata (ram_q)
  );
  // Subtraction is two's complement; carry/borrow fall off the top
  assign alu = su ? a - b : a + b;
  // Bus mux in fixed priority so simultaneous drivers still give a defined value
  always_comb
    w_bus = ep ? {{(DATA_W-ADDR_W){1'b0}}, pc} :
            ce ? ram_q :
            ei ? {{(DATA_W-4){1'b0}}, ir[3:0]} :
            ea ? a :
            eu ? alu : '0;
  assign conflict = (ep && (ce || ei || ea || eu)) || (ce && (ei || ea || eu)) ||
                    (ei && (ea || eu)) || (ea && eu);
  assign opcode = ir[DATA_W-1 -: 4];
  // Register file; a register driving the bus ignores its own load so it holds
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      pc <= '0;
      mar <= '0;
      ir <= '0;
      a <= '0;
      b <= '0;
      out_reg <= '0;
      bus_conflict <= 1'b0;
    end else if (!prog_mode) begin
      if (cp) pc <= pc + ADDR_W'(1);
      if (lm) mar <= w_bus[ADDR_W-1:0];
      if (li && !ei) ir <= w_bus;
      if (la && !ea) a <= w_bus;
      if (lb) b <= w_bus;
      if (lo) out_reg <= w_bus;
      if (conflict) bus_conflict <= 1'b1;
    end
endmodule

// File: tb/tb_sap1_datapath.sv
// tb_sap1_datapath: directed self-checking bench for the SAP-1 datapath
module tb_sap1_datapath;
  import sap1_pkg::*;
  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
  logic CLK = 1'b0, CLR = 1'b0;
  logic [11:0] cntrl_bus = CW_IDLE;
  logic prog_mode = 1'b0, prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [3:0] opcode;
  logic [7:0] out_reg, w_bus;
  logic bus_conflict;
  int checks = 0, failures = 0;
  sap1_datapath dut (
    .CLK          (CLK),
    .CLR          (CLR),
    .cntrl_bus    (cntrl_bus),
    .prog_mode    (prog_mode),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .opcode       (opcode),
    .out_reg      (out_reg),
    .w_bus        (w_bus),
    .bus_conflict (bus_conflict)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Active strobes toggle away from idle: XOR drops active-low bits and raises active-high ones
  task automatic cyc(input logic [11:0] m);
    cntrl_bus = CW_IDLE ^ m;
    @(posedge CLK);
    #1;
  endtask
  task automatic peek(input logic [11:0] m);
    cntrl_bus = CW_IDLE ^ m;
    #1;
  endtask
  task automatic wr(input logic [3:0] ad, input logic [7:0] d);
    prog_mode = 1'b1;
    prog_we = 1'b1;
    prog_addr = ad;
    prog_data = d;
    cyc(CP | LA);
    prog_we = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_out", out_reg, 8'h00);
    chk("rst_opcode", {4'h0, opcode}, 8'h00);
    chk("rst_conflict", {7'h0, bus_conflict}, 8'h00);
    peek(EP);
    chk("rst_pc", w_bus, 8'h00);
    peek(0);
    chk("idle_bus", w_bus, 8'h00);
    CLR = 1'b1;
    wr(4'd0, 8'h1A);
    wr(4'd1, 8'h05);
    wr(4'd2, 8'h07);
    wr(4'd3, 8'hFF);
    wr(4'd4, 8'h01);
    peek(EP);
    chk("prog_pc_hold", w_bus, 8'h00);
    cyc(EP | EA);
    chk("prog_no_conflict", {7'h0, bus_conflict}, 8'h00);
    prog_mode = 1'b0;
    cyc(EP | LM);
    cyc(CP);
    cyc(CE | LI);
    chk("fetch_opcode", {4'h0, opcode}, {4'h0, ADD});
    peek(EP);
    chk("fetch_pc", w_bus, 8'h01);
    peek(EI);
    chk("fetch_ir_lo", w_bus, 8'h0A);
    peek(CE);
    chk("fetch_mar0", w_bus, 8'h1A);
    cyc(EP | LM);
    cyc(CE | LA);
    cyc(CP);
    cyc(EP | LM);
    cyc(CE | LB);
    peek(EU | SU);
    chk("sub_comb", w_bus, 8'hFE);
    cyc(EU | SU | LA);
    peek(EA);
    chk("sub_a", w_bus, 8'hFE);
    cyc(EA | LO);
    chk("out_fe", out_reg, 8'hFE);
    cyc(CP);
    cyc(EP | LM);
    cyc(CE | LA);
    cyc(CP);
    cyc(EP | LM);
    peek(CE);
    chk("ram_read_after_mar", w_bus, 8'h01);
    cyc(CE | LB);
    peek(EU);
    chk("add_wrap_comb", w_bus, 8'h00);
    cyc(EU | LA);
    peek(EA);
    chk("add_wrap_a", w_bus, 8'h00);
    #1 CLR = 1'b0;
    #1;
    chk("mid_rst_out", out_reg, 8'h00);
    chk("mid_rst_opcode", {4'h0, opcode}, 8'h00);
    peek(EP);
    chk("mid_rst_pc", w_bus, 8'h00);
    peek(CE);
    chk("ram_kept", w_bus, 8'h1A);
    CLR = 1'b1;
    repeat (17) cyc(CP);
    peek(EP);
    chk("pc_wrap", w_bus, 8'h01);
    cyc(CE | LA);
    peek(EP | EA);
    chk("prio_bus", w_bus, 8'h01);
    chk("pre_conflict", {7'h0, bus_conflict}, 8'h00);
    cyc(EP | EA);
    chk("conflict_set", {7'h0, bus_conflict}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      cyc(0);
      chk("conflict_sticky", {7'h0, bus_conflict}, 8'h01);
    end
    #1 CLR = 1'b0;
    #1;
    chk("conflict_clr", {7'h0, bus_conflict}, 8'h00);
    #1 CLR = 1'b1;
    cyc(CP);
    cyc(CE | LA);
    prog_mode = 1'b1;
    peek(EP);
    chk("prog_bus_decode", w_bus, 8'h01);
    prog_we = 1'b1;
    prog_addr = 4'd15;
    prog_data = 8'hE0;
    cyc(CP | LA);
    prog_we = 1'b0;
    prog_mode = 1'b0;
    peek(EP);
    chk("prog_pc_kept", w_bus, 8'h01);
    peek(EA);
    chk("prog_a_kept", w_bus, 8'h1A);
    repeat (14) cyc(CP);
    peek(EP);
    chk("pc15", w_bus, 8'h0F);
    cyc(EP | LM);
    peek(CE);
    chk("ram15", w_bus, 8'hE0);
    cyc(CE | LO);
    chk("out_e0", out_reg, 8'hE0);
    cntrl_bus = CW_IDLE;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
